// File: rtl/object_draw_engine.sv
// Rasterises one sprite/screen/erase object into VGA plots, one pixel per clock, then pulses done.
// Optional macro TRANSPARENT_EN: sprite pixels in TRANSPARENT_COLOUR are not plotted.
module object_draw_engine #(
    parameter int         SCREEN_W           = 160,
    parameter int         SCREEN_H           = 120,
    parameter int         ENEMY_W            = 8,
    parameter int         ENEMY_H            = 8,
    parameter int         PLAYER_W           = 10,
    parameter int         PLAYER_H           = 10,
    parameter logic [2:0] BG_COLOUR          = 3'b000,
    parameter logic [2:0] TRANSPARENT_COLOUR = 3'b101
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        draw_req,
    input  logic [3:0]  object_code,
    input  logic [7:0]  obj_x,
    input  logic [6:0]  obj_y,
    input  logic [2:0]  rom_data,
    output logic [3:0]  rom_sel,
    output logic [14:0] rom_addr,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE, S_REL} state_t;

    localparam logic [8:0] SW9 = 9'(SCREEN_W);
    localparam logic [7:0] SH8 = 8'(SCREEN_H);
`ifdef TRANSPARENT_EN
    localparam bit TRANSP_ON = 1'b1;
`else
    localparam bit TRANSP_ON = 1'b0;
`endif

    state_t      state_q;
    logic [3:0]  sel_q;
    logic [7:0]  ox_q, w_q, col_q, vga_x_q;
    logic [6:0]  oy_q, h_q, row_q, vga_y_q;
    logic [14:0] addr_q;
    logic        vld_q, plot_q, done_q;

    logic [7:0]  w_d;
    logic [6:0]  h_d;
    logic        full_d, valid_d, last_d;
    logic [8:0]  x_d;
    logic [7:0]  y_d;
    logic [2:0]  colour_d;

    // Box size and origin override are decoded from the live code, used only at the IDLE edge.
    always_comb begin
        w_d     = 8'(ENEMY_W);
        h_d     = 7'(ENEMY_H);
        full_d  = 1'b0;
        valid_d = 1'b1;
        if (object_code == 4'd5) begin
            w_d = 8'(PLAYER_W);
            h_d = 7'(PLAYER_H);
        end else if (object_code >= 4'd6 && object_code <= 4'd8) begin
            w_d    = 8'(SCREEN_W);
            h_d    = 7'(SCREEN_H);
            full_d = 1'b1;
        end else if (object_code > 4'd8) begin
            valid_d = 1'b0;
        end
    end

    assign x_d    = {1'b0, ox_q} + {1'b0, col_q};
    assign y_d    = {1'b0, oy_q} + {1'b0, row_q};
    assign last_d = (col_q == w_q - 8'd1) && (row_q == h_q - 7'd1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            vga_x_q <= '0;
            vga_y_q <= '0;
            vld_q   <= 1'b0;
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    vld_q  <= 1'b0;
                    plot_q <= 1'b0;
                    if (draw_req) begin
                        sel_q  <= object_code;
                        ox_q   <= full_d ? 8'd0 : obj_x;
                        oy_q   <= full_d ? 7'd0 : obj_y;
                        w_q    <= w_d;
                        h_q    <= h_d;
                        col_q  <= '0;
                        row_q  <= '0;
                        addr_q <= '0;
                        if (valid_d) begin
                            state_q <= S_SCAN;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (!draw_req) begin
                        state_q <= S_IDLE;
                        vld_q   <= 1'b0;
                        plot_q  <= 1'b0;
                    end else begin
                        vga_x_q <= x_d[7:0];
                        vga_y_q <= y_d[6:0];
                        vld_q   <= 1'b1;
                        plot_q  <= (x_d < SW9) && (y_d < SH8);
                        // addr tracks row*W+col as a running raster index
                        if (last_d) begin
                            state_q <= S_FLUSH;
                        end else begin
                            addr_q <= addr_q + 15'd1;
                            if (col_q == w_q - 8'd1) begin
                                col_q <= '0;
                                row_q <= row_q + 7'd1;
                            end else begin
                                col_q <= col_q + 8'd1;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    vld_q  <= 1'b0;
                    plot_q <= 1'b0;
                    if (!draw_req) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_REL;
                S_REL:   if (!draw_req) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ROM data lands in the same cycle as the registered coordinates, so colour is combinational.
    assign colour_d   = (sel_q == 4'd8) ? BG_COLOUR : rom_data;
    assign vga_colour = vld_q ? colour_d : 3'b000;
    assign vga_plot   = plot_q && !(TRANSP_ON && (sel_q <= 4'd5) && (colour_d == TRANSPARENT_COLOUR));
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign rom_sel    = sel_q;
    assign rom_addr   = addr_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
endmodule

// File: tb/tb_object_draw_engine.sv
// Randomised bench for object_draw_engine: a raster model predicts every output on every cycle.
module tb_object_draw_engine;
    logic        clk = 1'b0, resetn = 1'b0, draw_req = 1'b0;
    logic [3:0]  object_code = '0;
    logic [7:0]  obj_x = '0;
    logic [6:0]  obj_y = '0;
    logic [2:0]  rom_data = '0;
    logic [3:0]  rom_sel;
    logic [14:0] rom_addr;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy, done;

    object_draw_engine dut (
        .clk(clk), .resetn(resetn), .draw_req(draw_req), .object_code(object_code),
        .obj_x(obj_x), .obj_y(obj_y), .rom_data(rom_data), .rom_sel(rom_sel),
        .rom_addr(rom_addr), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // current draw as seen by the model
    int m_code = 0, m_ox = 0, m_oy = 0, m_mode = 0, m_seed = 0;
    int t0 = 0, c_end = 0;
    bit active = 1'b0, mon_on = 1'b0;
    int plot_cnt, done_n, done_c, first_x, first_y, last_x, last_y;

    function automatic int npix(input int code);
        if (code <= 4) return 64;
        if (code == 5) return 100;
        if (code <= 8) return 19200;
        return 0;
    endfunction

    function automatic int box_w(input int code);
        if (code <= 4) return 8;
        if (code == 5) return 10;
        return 160;
    endfunction

    function automatic logic [2:0] rom_fn(input int mode, input int code, input int addr, input int seed);
        if (mode == 0) return 3'b100;
        if (mode == 1) return (addr % 2 == 0) ? 3'b101 : 3'b010;
        return 3'((addr * 5 + code * 3 + seed) % 8);
    endfunction

    // synchronous sprite ROM: data follows the address by one clock
    always @(posedge clk) rom_data <= rom_fn(m_mode, int'(rom_sel), int'(rom_addr), m_seed);

    function automatic void pix(input int k, output bit pl, output int x, output int y, output logic [2:0] col);
        int w;
        bit full;
        w    = box_w(m_code);
        full = (m_code >= 6);
        x    = (full ? 0 : m_ox) + k % w;
        y    = (full ? 0 : m_oy) + k / w;
        col  = (m_code == 8) ? 3'b000 : rom_fn(m_mode, m_code, k, m_seed);
        pl   = (x < 160) && (y < 120);
`ifdef TRANSPARENT_EN
        if (m_code <= 5 && col == 3'b101) pl = 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    always @(negedge clk) if (mon_on) begin
        int c, n, ex, ey;
        bit eb, ed, ep;
        logic [2:0] ec;
        c  = edge_n - t0;
        eb = 1'b0; ed = 1'b0; ep = 1'b0; ex = 0; ey = 0; ec = '0;
        if (active && c >= 0 && c < c_end) begin
            n  = npix(m_code);
            eb = 1'b1;
            if (n == 0) begin
                ed = (c == 0);
            end else begin
                ed = (c == n + 1);
                if (c >= 1 && c <= n) pix(c - 1, ep, ex, ey, ec);
                if (c < n) chk("rom_addr", int'(rom_addr), c);
                else if (c <= n + 1) chk("rom_addr_hold", int'(rom_addr), n - 1);
            end
            chk("rom_sel", int'(rom_sel), m_code);
        end
        chk("busy", int'(busy), int'(eb));
        chk("done", int'(done), int'(ed));
        chk("vga_plot", int'(vga_plot), int'(ep));
        if (ep && vga_plot) begin
            chk("vga_x", int'(vga_x), ex);
            chk("vga_y", int'(vga_y), ey);
            chk("vga_colour", int'(vga_colour), int'(ec));
        end
        if (active && vga_plot) begin
            plot_cnt++;
            if (plot_cnt == 1) begin first_x = int'(vga_x); first_y = int'(vga_y); end
            last_x = int'(vga_x); last_y = int'(vga_y);
        end
        if (active && done) begin done_n++; done_c = c; end
    end

    // Start a draw, hold req, then drop it (or pulse reset) at model cycle 'stop'; scramble latched inputs meanwhile.
    task automatic draw(input int code, input int x, input int y, input int mode,
                        input int hold, input int abort_at, input bit by_reset);
        int n, stop;
        m_code = code; m_ox = x; m_oy = y; m_mode = mode; m_seed = $urandom_range(0, 999);
        plot_cnt = 0; done_n = 0; done_c = -1;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        object_code = 4'(code); obj_x = 8'(x); obj_y = 7'(y); draw_req = 1'b1;
        t0 = edge_n + 1; c_end = 1 << 30; active = 1'b1;
        n = npix(code);
        if (abort_at >= 1) stop = abort_at;
        else if (n == 0) stop = 2 + hold;
        else stop = n + 3 + hold;
        while (edge_n < t0 + stop - 1) begin
            @(posedge clk); #1;
            object_code = 4'($urandom); obj_x = 8'($urandom); obj_y = 7'($urandom);
        end
        c_end = stop;
        if (by_reset) begin
            resetn = 1'b0;
            @(posedge clk); #1;
            resetn = 1'b1;
            draw_req = 1'b0;
        end else begin
            draw_req = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        active = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "timeout");
    end

    initial begin
        int code, n, ab;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_plot", int'(vga_plot), 0);
        chk("reset_rom_sel", int'(rom_sel), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_vga_x", int'(vga_x), 0);
        chk("reset_vga_y", int'(vga_y), 0);
        chk("reset_colour", int'(vga_colour), 0);
        resetn = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        draw(0, 20, 30, 0, 3, -1, 1'b0);
        chk("enemy_plots", plot_cnt, 64);
        chk("enemy_first_x", first_x, 20);
        chk("enemy_first_y", first_y, 30);
        chk("enemy_last_x", last_x, 27);
        chk("enemy_last_y", last_y, 37);
        chk("enemy_done_cycle", done_c, 65);
        chk("enemy_done_count", done_n, 1);

        draw(8, 77, 99, 2, 0, -1, 1'b0);
        chk("erase_plots", plot_cnt, 19200);
        chk("erase_first_x", first_x, 0);
        chk("erase_last_x", last_x, 159);
        chk("erase_last_y", last_y, 119);
        chk("erase_done_cycle", done_c, 19201);

        draw(5, 155, 115, 2, 1, -1, 1'b0);
        chk("player_clip_plots", plot_cnt, 25);
        chk("player_first_x", first_x, 155);
        chk("player_first_y", first_y, 115);
        chk("player_done_cycle", done_c, 101);

        draw(10, 5, 5, 2, 6, -1, 1'b0);
        chk("invalid_plots", plot_cnt, 0);
        chk("invalid_done_cycle", done_c, 0);
        chk("invalid_done_count", done_n, 1);

        draw(0, 20, 30, 0, 0, 31, 1'b1);
        chk("reset_abort_plots", plot_cnt, 30);
        chk("reset_abort_done", done_n, 0);

        draw(0, 20, 30, 0, 0, 31, 1'b0);
        chk("req_abort_plots", plot_cnt, 30);
        chk("req_abort_done", done_n, 0);

        draw(2, 50, 50, 1, 0, -1, 1'b0);
`ifdef TRANSPARENT_EN
        chk("alt_rom_plots", plot_cnt, 32);
`else
        chk("alt_rom_plots", plot_cnt, 64);
`endif

        for (int i = 0; i < 24; i++) begin
            code = $urandom_range(0, 9);
            if (code > 5) code = 9 + $urandom_range(0, 6);
            n  = npix(code);
            ab = -1;
            if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, n + 1);
            draw(code, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 2),
                 $urandom_range(0, 4), ab, 1'($urandom_range(0, 1)));
            if (ab < 0) chk("rand_done_count", done_n, 1);
            else chk("rand_abort_no_done", done_n, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
